// File: rtl/apb_cmd_master_if.sv
// Signal bundle for apb_cmd_master: host command stream, response stream and APB requester bus.
// The master modport is the block's view; the slave modport is the host/APB-completer side.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Valid/ready command stream to APB SETUP/ACCESS requester, one transfer in flight.
// Optional macro APB_TIMEOUT_EN adds an ACCESS-phase wait-state limit of TIMEOUT_CYCLES.
module apb_cmd_master #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_cmd_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state_q, state_nxt;
  logic              cmd_ready_q, cmd_ready_nxt;
  logic              psel_q, psel_nxt;
  logic              penable_q, penable_nxt;
  logic              pwrite_q, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_q, paddr_nxt;
  logic [DATA_W-1:0] pwdata_q, pwdata_nxt;
  logic              rsp_valid_q, rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_nxt;
  logic              rsp_err_q, rsp_err_nxt;
  logic              accept;

  assign accept = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;

`ifdef APB_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  // Counts ACCESS wait states; a fresh transfer always starts from zero.
  always_comb begin
    cnt_nxt = cnt_q;
    if (accept) begin
      cnt_nxt = '0;
    end else if (state_q == ACCESS && !bus.PREADY) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_nxt     = state_q;
    psel_nxt      = psel_q;
    penable_nxt   = penable_q;
    pwrite_nxt    = pwrite_q;
    paddr_nxt     = paddr_q;
    pwdata_nxt    = pwdata_q;
    rsp_valid_nxt = rsp_valid_q;
    rsp_rdata_nxt = rsp_rdata_q;
    rsp_err_nxt   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pwrite_nxt  = bus.cmd_write;
          paddr_nxt   = bus.cmd_addr;
          pwdata_nxt  = bus.cmd_wdata;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over an expiring timeout on the same cycle.
        if (bus.PREADY) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_rdata_nxt = pwrite_q ? {DATA_W{1'b0}} : bus.PRDATA;
          rsp_err_nxt   = bus.PSLVERR;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
`ifdef APB_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_rdata_nxt = {DATA_W{1'b0}};
          rsp_err_nxt   = 1'b1;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    cmd_ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cmd_ready_q <= cmd_ready_nxt;
      psel_q      <= psel_nxt;
      penable_q   <= penable_nxt;
      pwrite_q    <= pwrite_nxt;
      paddr_q     <= paddr_nxt;
      pwdata_q    <= pwdata_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      rsp_err_q   <= rsp_err_nxt;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
